ptr_sync_r2w: RTL and testbench

PTR_SYNC_R2W -- requirements
Module: ptr_sync_r2w

---
 rtl/ptr_sync_r2w_if.sv | 25 ++
 rtl/ptr_sync_r2w.sv | 98 +++++++++
 tb/tb_ptr_sync_r2w.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ptr_sync_r2w_if.sv
// Bundle of per-channel read-pointer inputs and synchronized outputs for ptr_sync_r2w.
// Channel c occupies bits [c*(ADDRSIZE+1) +: ADDRSIZE+1] in every pointer vector.
interface ptr_sync_r2w_if #(
  parameter int ADDRSIZE = 4,
  parameter int CHANNELS = 1
);
  localparam int PW = ADDRSIZE + 1;

  logic [CHANNELS*PW-1:0] rptr;
  logic [CHANNELS-1:0]    err_clr;
  logic [CHANNELS*PW-1:0] wq_rptr;
  logic [CHANNELS*PW-1:0] wq_rbin;
  logic [CHANNELS-1:0]    wq_rchg;
  logic [CHANNELS-1:0]    wq_rerr;

  modport master (
    output rptr, err_clr,
    input  wq_rptr, wq_rbin, wq_rchg, wq_rerr
  );

  modport slave (
    input  rptr, err_clr,
    output wq_rptr, wq_rbin, wq_rchg, wq_rerr
  );
endinterface

// File: rtl/ptr_sync_r2w.sv
// Multi-channel Gray read-pointer synchronizer into the write domain, with binary
// conversion, change pulse and optional Gray-coherence checker (PTR_SYNC_GRAY_CHECK_EN).
module ptr_sync_r2w #(
  parameter int ADDRSIZE = 4,
  parameter int STAGES   = 2,
  parameter int CHANNELS = 1
) (
  input  logic          wclk,
  input  logic          wrst,
  ptr_sync_r2w_if.slave bus
);
  localparam int PW = ADDRSIZE + 1;

  typedef logic [PW-1:0] ptr_t;

  logic [CHANNELS-1:0][STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][PW-1:0]             rbin_q, rbin_d;
  logic [CHANNELS-1:0][PW-1:0]             prev_q, prev_d;
  logic [CHANNELS-1:0]                     rchg_q, rchg_d;

  ptr_t last;
  ptr_t bin;

`ifdef PTR_SYNC_GRAY_CHECK_EN
  logic [CHANNELS-1:0] rerr_q, rerr_d;
  ptr_t                diff;
`endif

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    sync_d = sync_q;
    rbin_d = rbin_q;
    prev_d = prev_q;
    rchg_d = '0;
    last   = '0;
    bin    = '0;
`ifdef PTR_SYNC_GRAY_CHECK_EN
    rerr_d = rerr_q;
    diff   = '0;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      sync_d[c][0] = bus.rptr[c*PW +: PW];
      for (int s = 1; s < STAGES; s++) begin
        sync_d[c][s] = sync_q[c][s-1];
      end

      last        = sync_q[c][STAGES-1];
      bin[PW-1]   = last[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
        bin[i] = bin[i+1] ^ last[i];
      end
      rbin_d[c] = bin;
      prev_d[c] = last;
      rchg_d[c] = (last != prev_q[c]);

`ifdef PTR_SYNC_GRAY_CHECK_EN
      // More than one bit set in the XOR means a non-Gray step; a new error beats a clear.
      diff      = last ^ prev_q[c];
      rerr_d[c] = ((diff & (diff - PW'(1))) != '0) | (rerr_q[c] & ~bus.err_clr[c]);
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset zeroes every flop.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      sync_q <= '0;
      rbin_q <= '0;
      prev_q <= '0;
      rchg_q <= '0;
`ifdef PTR_SYNC_GRAY_CHECK_EN
      rerr_q <= '0;
`endif
    end else begin
      sync_q <= sync_d;
      rbin_q <= rbin_d;
      prev_q <= prev_d;
      rchg_q <= rchg_d;
`ifdef PTR_SYNC_GRAY_CHECK_EN
      rerr_q <= rerr_d;
`endif
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    assign bus.wq_rptr[c*PW +: PW] = sync_q[c][STAGES-1];
    assign bus.wq_rbin[c*PW +: PW] = rbin_q[c];
  end

  assign bus.wq_rchg = rchg_q;

`ifdef PTR_SYNC_GRAY_CHECK_EN
  assign bus.wq_rerr = rerr_q;
`else
  assign bus.wq_rerr = '0;
`endif

endmodule

// File: tb/tb_ptr_sync_r2w.sv
// Scoreboard bench for ptr_sync_r2w: a history-based reference model pushes expected
// outputs per edge; a monitor on the falling edge pops and compares.
module tb_ptr_sync_r2w;
  localparam int ADDRSIZE = 4;
  localparam int STAGES   = 2;
  localparam int CH       = 2;
  localparam int PW       = ADDRSIZE + 1;
  localparam int DEPTH    = STAGES + 2;

`ifdef PTR_SYNC_GRAY_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef logic [PW-1:0] ptr_t;

  typedef struct {
    logic [CH*PW-1:0] rptr;
    logic [CH*PW-1:0] rbin;
    logic [CH-1:0]    chg;
    logic [CH-1:0]    err;
  } exp_t;

  logic wclk = 1'b0;
  logic wrst;

  ptr_sync_r2w_if #(.ADDRSIZE(ADDRSIZE), .CHANNELS(CH)) bus ();

  ptr_sync_r2w #(.ADDRSIZE(ADDRSIZE), .STAGES(STAGES), .CHANNELS(CH)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus.slave)
  );

  always #5 wclk = ~wclk;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t sb_q[$];

  // Model state: samples taken at each edge, newest at index 0.
  ptr_t    hist [CH][DEPTH];
  logic    err_m [CH];
  int      bcnt [CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b = '0;
    for (int sh = 0; sh < PW; sh++) b ^= (g >> sh);
    return b;
  endfunction

  // Called right after each rising edge, while the inputs the DUT just sampled are still applied.
  task automatic model_edge();
    exp_t e;
    ptr_t cur, old;
    e.rptr = '0; e.rbin = '0; e.chg = '0; e.err = '0;
    for (int c = 0; c < CH; c++) begin
      if (wrst) begin
        for (int i = 0; i < DEPTH; i++) hist[c][i] = '0;
        err_m[c] = 1'b0;
      end else begin
        for (int i = DEPTH - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
        hist[c][0] = bus.rptr[c*PW +: PW];
      end
      cur = hist[c][STAGES];
      old = hist[c][STAGES+1];
      if (!wrst) begin
        if (CHK_EN) err_m[c] = ($countones(cur ^ old) > 1) || (err_m[c] && !bus.err_clr[c]);
        else        err_m[c] = 1'b0;
      end
      e.rptr[c*PW +: PW] = hist[c][STAGES-1];
      e.rbin[c*PW +: PW] = gray2bin(cur);
      e.chg[c]           = (cur != old);
      e.err[c]           = err_m[c];
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input ptr_t g0, input ptr_t g1, input logic [CH-1:0] clr, input logic rst);
    bus.rptr    = {g1, g0};
    bus.err_clr = clr;
    wrst        = rst;
    @(posedge wclk);
    model_edge();
    #1;
  endtask

  task automatic step_both(input logic [CH-1:0] clr);
    for (int c = 0; c < CH; c++) bcnt[c] = (bcnt[c] + 1) % (1 << PW);
    drive(bin2gray(ptr_t'(bcnt[0])), bin2gray(ptr_t'(bcnt[1])), clr, 1'b0);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("wq_rptr", 64'(bus.wq_rptr), 64'(e.rptr));
        check("wq_rbin", 64'(bus.wq_rbin), 64'(e.rbin));
        check("wq_rchg", 64'(bus.wq_rchg), 64'(e.chg));
        check("wq_rerr", 64'(bus.wq_rerr), 64'(e.err));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ptr_t g0, g1;
    int   r;
    for (int c = 0; c < CH; c++) begin
      bcnt[c]  = 0;
      err_m[c] = 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[c][i] = '0;
    end
    bus.rptr    = '1;
    bus.err_clr = '0;
    wrst        = 1'b1;
    #1;

    // Reset with all-ones on the pointer input: nothing may be captured.
    repeat (3) drive('1, '1, 2'b11, 1'b1);

    // Latency: channel 0 steps 0 -> 1, then holds.
    drive('0, '0, '0, 1'b0);
    drive(5'b00001, '0, '0, 1'b0);
    repeat (4) drive(5'b00001, '0, '0, 1'b0);

    // Wrap: both channels count through the full Gray sequence and back to 0.
    bcnt[0] = 1; bcnt[1] = 0;
    for (int n = 0; n < 40; n++) step_both('0);
    while (bcnt[0] != 0) step_both('0);
    repeat (4) drive(bin2gray(ptr_t'(bcnt[0])), bin2gray(ptr_t'(bcnt[1])), '0, 1'b0);

    // Error / clear / collision on channel 0; channel 1 held.
    g1 = bin2gray(ptr_t'(bcnt[1]));
    drive(5'b00000, g1, '0, 1'b0);
    repeat (3) drive(5'b00000, g1, '0, 1'b0);
    drive(5'b00011, g1, '0, 1'b0);            // two-bit jump
    repeat (4) drive(5'b00011, g1, '0, 1'b0); // error held
    drive(5'b00011, g1, 2'b01, 1'b0);         // clear
    repeat (2) drive(5'b00011, g1, '0, 1'b0);
    drive(5'b00000, g1, '0, 1'b0);            // second jump, no clear
    repeat (4) drive(5'b00000, g1, '0, 1'b0);
    drive(5'b00011, g1, '0, 1'b0);            // third jump, evaluated two edges later
    drive(5'b00011, g1, '0, 1'b0);
    drive(5'b00011, g1, 2'b01, 1'b0);         // clear coincides with the new error
    repeat (2) drive(5'b00011, g1, '0, 1'b0);
    drive(5'b00011, g1, 2'b01, 1'b0);         // plain clear
    repeat (2) drive(5'b00011, g1, '0, 1'b0);

    // Randomized traffic: legal steps, holds, jumps, clears and occasional reset.
    bcnt[0] = 2;
    for (int n = 0; n < 500; n++) begin
      logic [CH-1:0] clr;
      logic          rst;
      for (int c = 0; c < CH; c++) begin
        r = int'($urandom_range(0, 99));
        if (r < 55)      bcnt[c] = (bcnt[c] + 1) % (1 << PW);
        else if (r < 88) bcnt[c] = bcnt[c];
        else             bcnt[c] = int'($urandom_range(0, (1 << PW) - 1));
      end
      clr = ($urandom_range(0, 99) < 15) ? CH'($urandom) : '0;
      rst = ($urandom_range(0, 99) < 2);
      g0  = bin2gray(ptr_t'(bcnt[0]));
      g1  = bin2gray(ptr_t'(bcnt[1]));
      drive(g0, g1, clr, rst);
    end

    repeat (3) @(negedge wclk);
    check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
